imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_array.sv | 71 +++++++
 rtl/imem_fetch.sv | 136 +++++++++++++
 tb/tb_imem_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants for the instruction-memory fetch block:
//               default word width, NOP encoding, fault-counter width and
//               the output-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Default instruction word width
  localparam int c_DATA_W = 32;

  // NOP is the all-zeros word; faulted fetches return it
  localparam logic c_NOP_BIT = 1'b0;

  // Width of the saturating faulted-fetch counter
  localparam int c_FAULT_CNT_W = 8;

  // One-entry output stage
  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t c_ST_EMPTY = 1'b0;
  localparam fsm_state_t c_ST_FULL  = 1'b1;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : Instruction storage. One write port, one synchronous read
//               port, no reset (contents survive rst). A read that collides
//               with a write to the same index returns the old word.
// Revision    : 1.0 - initial release
// Config      : IMEM_PARITY_EN - keep one even-parity bit per word and
//               report a mismatch on the registered read data.
// Ports       : clk       - clock
//               i_we      - write strobe
//               i_widx    - write word index
//               i_wdata   - write word
//               i_re      - read enable (captures word into read register)
//               i_ridx    - read word index
//               o_rdata   - registered read word
//               o_par_err - parity mismatch on o_rdata (0 without parity)
// ============================================================================
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_par_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Non-blocking read/write gives read-old-data on a same-index collision
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_rpar;

  // Even parity: stored bit makes the total count of ones even
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_par[i_widx] <= ^i_wdata;
    end
    if (i_re) begin
      r_rpar <= r_par[i_ridx];
    end
  end

  assign o_par_err = (^r_rdata) ^ r_rpar;
`else
  assign o_par_err = 1'b0;
`endif

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Instruction fetch unit. Accepts byte-address fetch requests,
//               returns the addressed word one cycle later through a
//               one-entry output register with valid/ready flow control,
//               faults misaligned / out-of-range fetches (returning NOP) and
//               counts faulted fetches with a saturating counter.
// Revision    : 1.0 - initial release
// Config      : IMEM_PARITY_EN - per-word parity; mismatch is a fault.
// Ports       : clk, rst              - clock, async active-high reset
//               req_valid/req_ready   - fetch request handshake
//               req_addr              - fetch byte address
//               rsp_valid/rsp_ready   - response handshake
//               rsp_data, rsp_fault   - fetched word, fault flag
//               load_we/idx/data      - program-load write port
//               fault_cnt             - saturating faulted-fetch count
// ============================================================================
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data,
  output logic [c_FAULT_CNT_W-1:0] fault_cnt
);

  localparam int c_IDX_W = $clog2(DEPTH);

  fsm_state_t               r_state;
  fsm_state_t               w_state_nxt;
  logic                     r_addr_fault;
  logic                     r_fresh;
  logic [c_FAULT_CNT_W-1:0] r_fault_cnt;

  logic [c_IDX_W-1:0] w_idx;
  logic               w_misalign;
  logic               w_oor;
  logic               w_accept;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_par_err;
  logic               w_fault;

  assign w_idx      = req_addr[c_IDX_W+1:2];
  assign w_misalign = |req_addr[1:0];
  assign w_oor      = |req_addr[ADDR_W-1:c_IDX_W+2];
  assign w_accept   = req_valid && req_ready;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_IDX_W)
  ) u_array (
    .clk       (clk),
    .i_we      (load_we),
    .i_widx    (load_idx),
    .i_wdata   (load_data),
    .i_re      (w_accept),
    .i_ridx    (w_idx),
    .o_rdata   (w_rdata),
    .o_par_err (w_par_err)
  );

  // ---------------- output-stage FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- output-stage FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_accept) w_state_nxt = c_ST_FULL;
      c_ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = c_ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = c_ST_EMPTY;
        end
      end
      default: w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // ---------------- output-stage FSM: outputs ----------------
  always_comb begin
    rsp_valid = (r_state == c_ST_FULL);
    // rst gates ready so nothing is accepted while reset is held
    req_ready = !rst && ((r_state == c_ST_EMPTY) || rsp_ready);
  end

  // Address fault is registered with the fetch; r_fresh marks the first
  // cycle a response is presented so each accepted fetch is counted once
  // (parity status is only known once the read register is loaded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_fault <= 1'b0;
      r_fresh      <= 1'b0;
      r_fault_cnt  <= '0;
    end else begin
      r_fresh <= w_accept;
      if (w_accept) begin
        r_addr_fault <= w_misalign || w_oor;
      end
      if (r_fresh && w_fault && (r_fault_cnt != {c_FAULT_CNT_W{1'b1}})) begin
        r_fault_cnt <= r_fault_cnt + 1'b1;
      end
    end
  end

  assign w_fault   = r_addr_fault || w_par_err;
  assign rsp_fault = (r_state == c_ST_FULL) && w_fault;
  // Read register is not reset; gating by state keeps rsp_data zero in reset
  assign rsp_data  = ((r_state == c_ST_FULL) && !w_fault) ? w_rdata
                                                          : {DATA_W{c_NOP_BIT}};
  assign fault_cnt = r_fault_cnt;

endmodule : imem_fetch
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch
// Description : Scoreboard testbench for imem_fetch. Stimulus pushes the
//               expected response; a monitor pops and compares each newly
//               presented response (data, fault, presentation cycle).
// Revision    : 1.0 - initial release
// Config      : IMEM_PARITY_EN - adds the parity-corruption case.
// ============================================================================
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        load_we;
  logic [5:0]  load_idx;
  logic [31:0] load_data;
  logic [7:0]  fault_cnt;

  imem_fetch #(
    .DATA_W (32),
    .DEPTH  (64),
    .ADDR_W (32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .load_we   (load_we),
    .load_idx  (load_idx),
    .load_data (load_data),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [31:0] vals [4] = '{32'h00221000, 32'h00441000, 32'h00551000, 32'h00661000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is new when valid and the previous sample had
  // either no response or a consumed one.
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid && (!prev_v || prev_r)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data 0x%08h, want no response", rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
        check("rsp_cycle", cyc, e.at);
      end
    end
    prev_v = rsp_valid;
    prev_r = rsp_ready;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) break;
      @(posedge clk);
      #1;
    end
    if (n > 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0, want 1 (addr 0x%08h)", a);
      req_valid = 1'b0;
    end else begin
      e.data  = d;
      e.fault = f;
      e.at    = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    load_we   = 1'b0;
    load_idx  = '0;
    load_data = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    check("rst_fault_cnt", {24'b0, fault_cnt}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Program load
    for (int i = 0; i < 4; i++) begin
      load_we   = 1'b1;
      load_idx  = 6'(i);
      load_data = vals[i];
      @(posedge clk);
      #1;
    end
    load_we = 1'b0;

    // Back-to-back fetches; cycle check in the monitor proves one per cycle
    issue(32'h0, vals[0], 1'b0);
    issue(32'h4, vals[1], 1'b0);
    issue(32'h8, vals[2], 1'b0);
    issue(32'hC, vals[3], 1'b0);
    drain();

    // Consumer stall: response at 0x4 held, next fetch waits
    rsp_ready = 1'b0;
    issue(32'h4, vals[1], 1'b0);
    fork
      issue(32'h8, vals[2], 1'b0);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_data",  rsp_data, 32'h00441000);
      check("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drain();

    // Misaligned and out-of-range fetches
    issue(32'h2,   32'h0, 1'b1);
    issue(32'h100, 32'h0, 1'b1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("fault_cnt_2", {24'b0, fault_cnt}, 32'd2);

    for (int i = 0; i < 300; i++) begin
      issue((i % 2 == 0) ? 32'h1 : 32'h200, 32'h0, 1'b1);
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("fault_cnt_sat", {24'b0, fault_cnt}, 32'd255);

    // Load collides with fetch of same index: old word returned
    load_we   = 1'b1;
    load_idx  = 6'd1;
    load_data = 32'hFFFFFFFF;
    issue(32'h4, vals[1], 1'b0);
    load_we = 1'b0;
    issue(32'h4, 32'hFFFFFFFF, 1'b0);
    drain();

    // Reset while FULL: response dropped immediately, storage kept
    rsp_ready = 1'b0;
    issue(32'h0, vals[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid",     {31'b0, rsp_valid}, 32'd0);
    check("midrst_data",      rsp_data, 32'd0);
    check("midrst_fault_cnt", {24'b0, fault_cnt}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    #1 rst = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h0, vals[0], 1'b0);
    drain();

`ifdef IMEM_PARITY_EN
    force u_dut.u_array.r_par[2] = ~(^vals[2]);
    issue(32'h8, 32'h0, 1'b1);
    drain();
    release u_dut.u_array.r_par[2];
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_final_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_fetch
`default_nettype wire
